// File: rtl/exit_park_if.sv
// Handshake bundle between the exit controller and its neighbours:
// park/exit requests come in, occupancy, status pulses and fee go out.
interface exit_park_if #(
    parameter int SLOTS = 8
);
    localparam int IDX_W = $clog2(SLOTS);

    logic             park_in;
    logic [IDX_W-1:0] park_in_num;
    logic             exit_req;
    logic [IDX_W-1:0] exit_num;
    logic [SLOTS-1:0] parking_capacity;
    logic             busy;
    logic             exit_done;
    logic             exit_err;
    logic [15:0]      fee;

    modport master (
        output park_in, park_in_num, exit_req, exit_num,
        input  parking_capacity, busy, exit_done, exit_err, fee
    );

    modport slave (
        input  park_in, park_in_num, exit_req, exit_num,
        output parking_capacity, busy, exit_done, exit_err, fee
    );
endinterface

// File: rtl/exit_park.sv
// Exit-side slot controller: owns the occupancy bitmap, times each
// occupied slot in billing units and releases slots with a computed fee.
//
// state   | meaning
// IDLE    | waiting for exit_req
// CHECK   | latch elapsed time, test occupancy of requested slot
// ERR     | requested slot was empty; exit_err pulses on leaving
// BILL    | compute fee from latched elapsed time
// RELEASE | free slot, load fee; exit_done pulses on leaving
module exit_park #(
    parameter int SLOTS    = 8,
    parameter int TICK_DIV = 16,
    parameter int FEE_RATE = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    exit_park_if.slave  bus
);
    localparam int IDX_W = $clog2(SLOTS);
    localparam int PRE_W = $clog2(TICK_DIV);

    typedef enum logic [2:0] {IDLE, CHECK, ERR, BILL, RELEASE} state_t;

    state_t           state_q, state_d;
    logic [PRE_W-1:0] pre_cnt;
    logic             tick;
    logic [IDX_W-1:0] slot_r;
    logic [7:0]       elapsed_r;
    logic [15:0]      fee_next_r;
    logic [15:0]      fee_q;
    logic             done_q, err_q;
    logic [SLOTS-1:0] cap_q;
    logic [7:0]       cnt [SLOTS];
    logic             release_now;
    logic [15:0]      billable;

    assign tick        = (pre_cnt == PRE_W'(TICK_DIV - 1));
    assign release_now = (state_q == RELEASE);
    assign billable    = {8'h00, (elapsed_r == 8'd0) ? 8'd1 : elapsed_r};

    // Free-running prescaler that defines the billing time unit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   pre_cnt <= '0;
        else if (tick) pre_cnt <= '0;
        else          pre_cnt <= pre_cnt + 1'b1;
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic; exit_req is only looked at in IDLE so requests while busy are dropped.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.exit_req) state_d = CHECK;
            CHECK:   state_d = cap_q[slot_r] ? BILL : ERR;
            ERR:     state_d = IDLE;
            BILL:    state_d = RELEASE;
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Exit datapath: slot/elapsed latches, fee pipeline and registered status pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_r     <= '0;
            elapsed_r  <= '0;
            fee_next_r <= '0;
            fee_q      <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            if (state_q == IDLE && bus.exit_req) slot_r <= bus.exit_num;
            if (state_q == CHECK) elapsed_r <= cnt[slot_r];
            if (state_q == BILL) fee_next_r <= billable * 16'(FEE_RATE);
            if (release_now) fee_q <= fee_next_r;
            done_q <= release_now;
            err_q  <= (state_q == ERR);
        end
    end

    // Occupancy and per-slot timers; a release of slot_r beats a same-cycle park of that slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_q <= '0;
            for (int i = 0; i < SLOTS; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < SLOTS; i++) begin
                if (release_now && slot_r == IDX_W'(i)) begin
                    cap_q[i] <= 1'b0;
                    cnt[i]   <= '0;
                end else if (bus.park_in && bus.park_in_num == IDX_W'(i) && !cap_q[i]) begin
                    cap_q[i] <= 1'b1;
                    cnt[i]   <= '0;
                end else if (cap_q[i] && tick && cnt[i] != 8'hFF) begin
                    cnt[i] <= cnt[i] + 8'd1;
                end
            end
        end
    end

    assign bus.parking_capacity = cap_q;
    assign bus.busy             = (state_q != IDLE);
    assign bus.exit_done        = done_q;
    assign bus.exit_err         = err_q;
    assign bus.fee              = fee_q;
endmodule

// File: tb/tb_exit_park.sv
// Bench for exit_park: directed scenarios plus a random park/exit mix,
// checked against a tick-arithmetic model of occupancy time and fees.
module tb_exit_park;
    localparam int TICK_DIV = 16;
    localparam int FEE_RATE = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    exit_park_if #(.SLOTS(8)) bus();

    exit_park #(.SLOTS(8), .TICK_DIV(TICK_DIV), .FEE_RATE(FEE_RATE)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;
    int edge_cnt = 0;

    // Rising edges since reset release; a billing tick lands on every edge that is a multiple of TICK_DIV.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) edge_cnt <= 0;
        else        edge_cnt <= edge_cnt + 1;
    end

    bit occ [8];
    int park_edge [8];
    int fee_m = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] cap_m();
        logic [31:0] m = 0;
        for (int i = 0; i < 8; i++) m[i] = occ[i];
        return m;
    endfunction

    // Billing units seen by slot s when the request was sampled at edge n.
    function automatic int elapsed_m(input int s, input int n);
        int e = n / TICK_DIV - park_edge[s] / TICK_DIV;
        return (e > 255) ? 255 : e;
    endfunction

    function automatic int fee_of(input int e);
        return ((e < 1) ? 1 : e) * FEE_RATE;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic park(input int s);
        bus.park_in = 1'b1;
        bus.park_in_num = 3'(s);
        step();
        if (!occ[s]) begin
            occ[s] = 1'b1;
            park_edge[s] = edge_cnt;
        end
        bus.park_in = 1'b0;
        chk("park_map", bus.parking_capacity, cap_m());
    endtask

    task automatic do_exit(input int s);
        int n;
        int exp_fee;
        bus.exit_req = 1'b1;
        bus.exit_num = 3'(s);
        step();
        n = edge_cnt;
        bus.exit_req = 1'b0;
        chk("busy_check", bus.busy, 1);
        step();
        chk("busy_n1", bus.busy, 1);
        if (occ[s]) begin
            exp_fee = fee_of(elapsed_m(s, n));
            step();
            chk("done_early", bus.exit_done, 0);
            step();
            occ[s] = 1'b0;
            fee_m = exp_fee;
            chk("exit_done", bus.exit_done, 1);
            chk("no_err_on_ok", bus.exit_err, 0);
            chk("fee", bus.fee, fee_m);
            chk("map_release", bus.parking_capacity, cap_m());
            step();
            chk("done_pulse_end", bus.exit_done, 0);
            chk("idle_after_ok", bus.busy, 0);
        end else begin
            step();
            chk("exit_err", bus.exit_err, 1);
            chk("no_done_on_err", bus.exit_done, 0);
            chk("map_on_err", bus.parking_capacity, cap_m());
            chk("fee_on_err", bus.fee, fee_m);
            step();
            chk("err_pulse_end", bus.exit_err, 0);
            chk("idle_after_err", bus.busy, 0);
        end
    endtask

    initial begin
        int n;
        int guard;
        int exp_fee;
        int op;
        int s;

        bus.park_in = 1'b0;
        bus.park_in_num = '0;
        bus.exit_req = 1'b0;
        bus.exit_num = '0;
        for (int i = 0; i < 8; i++) begin
            occ[i] = 1'b0;
            park_edge[i] = 0;
        end

        #12;
        chk("rst_map", bus.parking_capacity, 0);
        chk("rst_fee", bus.fee, 0);
        chk("rst_busy", bus.busy, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Idle after reset: nothing moves.
        for (int i = 0; i < 40; i++) begin
            step();
            chk("idle_done", bus.exit_done, 0);
            chk("idle_err", bus.exit_err, 0);
            chk("idle_map", bus.parking_capacity, 0);
            chk("idle_fee", bus.fee, 0);
        end

        // Single park, wait five billing units, exit.
        park(3);
        repeat (5 * TICK_DIV) step();
        do_exit(3);
        chk("map_after_3", bus.parking_capacity, 0);

        // Exit of an empty slot among occupied ones.
        park(0); park(2); park(4); park(6);
        chk("map_55", bus.parking_capacity, 32'h55);
        do_exit(1);
        chk("map_55_kept", bus.parking_capacity, 32'h55);

        // Leave before any tick: minimum charge.
        guard = 0;
        while ((edge_cnt % TICK_DIV) != 2 && guard < 2 * TICK_DIV) begin
            step();
            guard++;
        end
        park(5);
        do_exit(5);
        chk("min_fee", bus.fee, FEE_RATE);
        chk("bit5_clear", bus.parking_capacity[5], 0);

        // Saturation of the elapsed timer.
        park(1);
        repeat (300 * TICK_DIV + 5) step();
        do_exit(1);
        chk("sat_fee", bus.fee, 255 * FEE_RATE);

        // Collisions: second request while busy, park during BILL, park of releasing slot on RELEASE edge.
        bus.exit_req = 1'b1;
        bus.exit_num = 3'd2;
        step();
        n = edge_cnt;
        exp_fee = fee_of(elapsed_m(2, n));
        step();
        bus.park_in = 1'b1;
        bus.park_in_num = 3'd7;
        step();
        if (!occ[7]) begin
            occ[7] = 1'b1;
            park_edge[7] = edge_cnt;
        end
        chk("park_in_bill", bus.parking_capacity[7], 1);
        bus.park_in_num = 3'd2;
        bus.exit_req = 1'b0;
        step();
        bus.park_in = 1'b0;
        occ[2] = 1'b0;
        fee_m = exp_fee;
        chk("coll_done", bus.exit_done, 1);
        chk("coll_fee", bus.fee, fee_m);
        chk("coll_bit2", bus.parking_capacity[2], 0);
        chk("coll_map", bus.parking_capacity, cap_m());
        for (int i = 0; i < 4; i++) begin
            step();
            chk("no_queued_err", bus.exit_err, 0);
            chk("no_queued_done", bus.exit_done, 0);
            chk("no_queued_busy", bus.busy, 0);
        end

        // Random park/exit/idle mix.
        for (int it = 0; it < 40; it++) begin
            op = $urandom_range(0, 2);
            s = $urandom_range(0, 7);
            case (op)
                0: park(s);
                1: do_exit(s);
                default: repeat ($urandom_range(1, 40)) step();
            endcase
        end

        // Reset while the exit is in CHECK.
        park(4);
        bus.exit_req = 1'b1;
        bus.exit_num = 3'd4;
        step();
        bus.exit_req = 1'b0;
        chk("abort_in_check", bus.busy, 1);
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 8; i++) occ[i] = 1'b0;
        fee_m = 0;
        chk("abort_map", bus.parking_capacity, 0);
        chk("abort_busy", bus.busy, 0);
        chk("abort_done", bus.exit_done, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("abort_no_done", bus.exit_done, 0);
            chk("abort_no_err", bus.exit_err, 0);
            chk("abort_map_hold", bus.parking_capacity, cap_m());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/exit_park.md
Name: exit_park

Overview:
- Exit-side counterpart of the entry slot allocator.
- Owns the 8-slot occupancy bitmap, which it exports as `parking_capacity` to the entry allocator.
  - Marks a slot occupied when a car is parked.
  - Times how long each slot stays occupied.
  - On an exit request: validates the slot, computes the fee, then frees the slot.
- Sits between the entry allocator and the exit gate / payment logic.

Parameters:
- SLOTS, 8, number of parking slots (bitmap width); slot index width is 3.
- TICK_DIV, 16, clock cycles per billing time unit (≥2).
- FEE_RATE, 2, fee units charged per elapsed time unit.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- park_in  input  1  one-cycle pulse: car parked in slot park_in_num.
- park_in_num  input  3  slot being occupied.
- exit_req  input  1  request to release slot exit_num; sampled only when busy=0.
- exit_num  input  3  slot whose car is leaving.
- parking_capacity  output  8  occupancy bitmap; bit i=1 means slot i is occupied.
- busy  output  1  FSM not in IDLE.
- exit_done  output  1  one-cycle pulse: slot released, fee valid.
- exit_err  output  1  one-cycle pulse: exit_req named an empty slot.
- fee  output  16  fee for the last successful exit; held until the next successful exit.

Behaviour:
- Reset (async, rst_n=0): all outputs and state are zero.
  - parking_capacity=0, fee=0, busy=0, exit_done=0, exit_err=0.
  - Prescaler=0, all elapsed counters=0, FSM=IDLE.
- Prescaler:
  - Counts 0..TICK_DIV-1 continuously.
  - tick=1 in the cycle where count==TICK_DIV-1.
- Elapsed counters (8 bits per slot):
  - On tick, every occupied slot's counter increments, saturating at 255.
  - Empty slots hold 0.
- park_in:
  - If slot park_in_num is empty: set its bit and clear its counter at the next edge.
  - If the slot is already occupied: ignored, no change.
  - Accepted in every FSM state, independent of busy.
- FSM states:
  - IDLE: if exit_req=1, latch exit_num into slot_r and go to CHECK.
  - CHECK:
    - Latch elapsed_r = counter[slot_r].
    - If parking_capacity[slot_r]=0, go to ERR; otherwise go to BILL.
  - ERR: exit_err=1 for this cycle; go to IDLE. Bitmap and fee unchanged.
  - BILL: fee_next = max(elapsed_r,1) × FEE_RATE, zero-extended to 16 bits; go to RELEASE.
  - RELEASE:
    - At the edge leaving this state: clear bit slot_r, clear its counter, load fee, pulse exit_done.
    - Go to IDLE.
- Latency:
  - exit_req sampled at edge N.
  - exit_done high during the cycle after edge N+3; parking_capacity bit clears at edge N+3.
  - exit_err high during the cycle after edge N+2.
- exit_req while busy=1: ignored and not queued.
- Same-slot collisions:
  - park_in for slot_r in the same cycle as the RELEASE edge: release wins, park_in is dropped, bit ends 0.
  - park_in for any other slot in the same cycle proceeds normally.
- Counter for slot_r keeps counting after CHECK; the latched elapsed_r is what is billed.
- The minimum charge is one time unit, so a car leaving before the first tick pays FEE_RATE.
- Reset asserted mid-exit: returns to IDLE immediately.
  - No exit_done or exit_err pulse is issued for the aborted request.
  - Bitmap is cleared.
- busy=1 in CHECK, ERR, BILL, RELEASE.

Test Plan:
- Reset then idle 40 cycles → parking_capacity=8'h00, fee=0, no exit_done/exit_err pulses.
- park_in slot 3, wait 5×16 cycles, exit_req slot 3 → exit_done exactly 4 edges after request, fee=10, parking_capacity=8'h00.
- park_in slots 0,2,4,6 (bitmap 8'h55), exit_req slot 1 → exit_err pulse 3 edges after request, bitmap stays 8'h55, fee unchanged.
- park_in slot 5 then immediate exit_req slot 5 (before any tick) → fee=2 (minimum charge), bit 5 cleared.
- Slot 1 occupied ≥300 ticks → elapsed saturates at 255, fee=510.
- Collisions and abort:
  - During busy, second exit_req for slot 2 is ignored.
  - park_in slot 7 during BILL sets bit 7.
  - park_in of the releasing slot on the RELEASE edge leaves that bit 0.
  - rst_n pulled low in CHECK → bitmap 8'h00, no exit_done pulse.
